// File: rtl/move_extractor_pkg.sv
// Shared chess types: board/move layout, piece indices, special-move codes and FSM states.
// A board is a set of piece bitboards (any colour) plus a colour mask and both king coordinates.
package move_extractor_pkg;

  localparam int NUM_PIECES = 5;

  typedef logic [2:0] ptype_t;
  localparam ptype_t PIECE_KNIGHT = 3'd0;
  localparam ptype_t PIECE_BISHOP = 3'd1;
  localparam ptype_t PIECE_ROOK   = 3'd2;
  localparam ptype_t PIECE_QUEEN  = 3'd3;
  localparam ptype_t PIECE_PAWN   = 3'd4;
  localparam ptype_t PIECE_KING   = 3'd5;
  localparam ptype_t PIECE_NONE   = 3'd7;

  typedef logic [5:0] coord_t;

  typedef logic [2:0] special_t;
  localparam special_t SPECIAL_UNKNOWN        = 3'd0;
  localparam special_t SPECIAL_CASTLE         = 3'd1;
  localparam special_t SPECIAL_EN_PASSANT     = 3'd2;
  localparam special_t SPECIAL_PROMOTE_KNIGHT = 3'd3;
  localparam special_t SPECIAL_PROMOTE_BISHOP = 3'd4;
  localparam special_t SPECIAL_PROMOTE_ROOK   = 3'd5;
  localparam special_t SPECIAL_PROMOTE_QUEEN  = 3'd6;

  // pieces_w bit = 1 marks a white piece on that square
  typedef struct packed {
    logic [NUM_PIECES-1:0][63:0] pieces;
    logic [63:0]                 pieces_w;
    coord_t                      king_w;
    coord_t                      king_b;
  } pos_t;

  typedef struct packed {
    pos_t       pos;
    logic [7:0] ply;
  } board_t;

  typedef struct packed {
    coord_t   src;
    coord_t   dst;
    special_t special;
  } move_t;

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;

  function automatic special_t promote_code(input ptype_t t);
    case (t)
      PIECE_KNIGHT: return SPECIAL_PROMOTE_KNIGHT;
      PIECE_BISHOP: return SPECIAL_PROMOTE_BISHOP;
      PIECE_ROOK:   return SPECIAL_PROMOTE_ROOK;
      default:      return SPECIAL_PROMOTE_QUEEN;
    endcase
  endfunction

endpackage

// File: rtl/move_extractor_diff_row.sv
// Classifies the 8 squares of one row: mover-owned vanish/appear masks and the
// piece type standing on each square before and after the move.
module move_diff_row
  import move_extractor_pkg::*;
#(
  parameter int NB_PIECES = NUM_PIECES
) (
  input  pos_t             before_i,
  input  pos_t             after_i,
  input  logic             side_i,
  input  logic [2:0]       row_i,
  output logic [7:0]       src_mask_o,
  output logic [7:0]       dst_mask_o,
  output ptype_t [7:0]     before_type_o,
  output ptype_t [7:0]     after_type_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sq
      coord_t               sq;
      logic [NB_PIECES-1:0] hit_b;
      logic [NB_PIECES-1:0] hit_a;
      logic                 own_b;
      logic                 own_a;
      ptype_t               type_b;
      ptype_t               type_a;

      assign sq = {row_i, 3'(gi)};

      genvar pi;
      for (pi = 0; pi < NB_PIECES; pi++) begin : g_pc
        assign hit_b[pi] = before_i.pieces[pi][sq];
        assign hit_a[pi] = after_i.pieces[pi][sq];
      end

      assign own_b = (side_i ? (before_i.king_b == sq) : (before_i.king_w == sq)) ||
                     ((|hit_b) && (before_i.pieces_w[sq] == ~side_i));
      assign own_a = (side_i ? (after_i.king_b == sq) : (after_i.king_w == sq)) ||
                     ((|hit_a) && (after_i.pieces_w[sq] == ~side_i));

      // Lowest piece index wins if a malformed board stacks pieces; kings override.
      always_comb begin
        type_b = PIECE_NONE;
        type_a = PIECE_NONE;
        for (int i = NB_PIECES - 1; i >= 0; i--) begin
          if (hit_b[i]) type_b = 3'(i);
          if (hit_a[i]) type_a = 3'(i);
        end
        if (before_i.king_w == sq || before_i.king_b == sq) type_b = PIECE_KING;
        if (after_i.king_w == sq || after_i.king_b == sq)   type_a = PIECE_KING;
      end

      assign src_mask_o[gi]    = own_b & ~own_a;
      assign dst_mask_o[gi]    = own_a & ~own_b;
      assign before_type_o[gi] = type_b;
      assign after_type_o[gi]  = type_a;
    end
  endgenerate

endmodule

// File: rtl/move_extractor.sv
// Recovers the move played between two board snapshots: scans one row per cycle,
// then resolves candidates into src/dst/special with a fixed 10-cycle latency.
module move_extractor
  import move_extractor_pkg::*;
#(
  parameter int NB_PIECES = NUM_PIECES
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  board_t before_in,
  input  board_t after_in,
  input  logic   valid_in,
  output logic   ready_out,
  output move_t  move_out,
  output logic   error_out,
  output logic   valid_out
);

  state_t     state_q;
  logic [2:0] row_q;
  pos_t       before_q, after_q;
  logic       side_q;
  logic [1:0] src_cnt_q, src_cnt_d, dst_cnt_q, dst_cnt_d;
  coord_t     src_q, src_d, dst_q, dst_d;
  ptype_t     src_type_q, src_type_d, dst_bt_q, dst_bt_d, dst_at_q, dst_at_d;
  move_t      move_q, move_d;
  logic       error_q, error_d;
  logic       valid_q, ready_q;

  logic [7:0]   src_mask, dst_mask;
  ptype_t [7:0] before_type, after_type;

  // Only the side-to-move bit of the ply counters matters.
  logic unused_ply_bits;
  assign unused_ply_bits = ^{before_in.ply[7:1], after_in.ply};

  move_diff_row #(.NB_PIECES(NB_PIECES)) u_row (
    .before_i      (before_q),
    .after_i       (after_q),
    .side_i        (side_q),
    .row_i         (row_q),
    .src_mask_o    (src_mask),
    .dst_mask_o    (dst_mask),
    .before_type_o (before_type),
    .after_type_o  (after_type)
  );

  always_comb begin
    src_cnt_d  = src_cnt_q;
    dst_cnt_d  = dst_cnt_q;
    src_d      = src_q;
    dst_d      = dst_q;
    src_type_d = src_type_q;
    dst_bt_d   = dst_bt_q;
    dst_at_d   = dst_at_q;
    for (int c = 0; c < 8; c++) begin
      if (src_mask[c]) begin
        if (src_cnt_d != 2'd2) src_cnt_d = src_cnt_d + 2'd1;
        src_d      = {row_q, 3'(c)};
        src_type_d = before_type[c];
      end
      if (dst_mask[c]) begin
        if (dst_cnt_d != 2'd2) dst_cnt_d = dst_cnt_d + 2'd1;
        dst_d    = {row_q, 3'(c)};
        dst_bt_d = before_type[c];
        dst_at_d = after_type[c];
      end
    end
  end

  coord_t     king_src, king_dst;
  logic [3:0] king_col_diff;

  assign king_src      = side_q ? before_q.king_b : before_q.king_w;
  assign king_dst      = side_q ? after_q.king_b  : after_q.king_w;
  assign king_col_diff = {1'b0, king_dst[2:0]} - {1'b0, king_src[2:0]};

  // A king move takes priority so the castling rook's own candidates are ignored.
  always_comb begin
    move_d  = '0;
    error_d = 1'b0;
    if (king_src != king_dst) begin
      move_d.src     = king_src;
      move_d.dst     = king_dst;
      move_d.special = (king_col_diff == 4'd2 || king_col_diff == 4'd14) ?
                       SPECIAL_CASTLE : SPECIAL_UNKNOWN;
    end else if (src_cnt_q == 2'd1 && dst_cnt_q == 2'd1) begin
      move_d.src     = src_q;
      move_d.dst     = dst_q;
      move_d.special = SPECIAL_UNKNOWN;
      if (src_type_q == PIECE_PAWN && dst_at_q <= PIECE_QUEEN) begin
        move_d.special = promote_code(dst_at_q);
      end else if (src_type_q == PIECE_PAWN && src_q[2:0] != dst_q[2:0] &&
                   dst_bt_q == PIECE_NONE) begin
        move_d.special = SPECIAL_EN_PASSANT;
      end
    end else begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      row_q      <= '0;
      before_q   <= '0;
      after_q    <= '0;
      side_q     <= 1'b0;
      src_cnt_q  <= '0;
      dst_cnt_q  <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      src_type_q <= PIECE_NONE;
      dst_bt_q   <= PIECE_NONE;
      dst_at_q   <= PIECE_NONE;
      move_q     <= '0;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            before_q   <= before_in.pos;
            after_q    <= after_in.pos;
            side_q     <= before_in.ply[0];
            src_cnt_q  <= '0;
            dst_cnt_q  <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            src_type_q <= PIECE_NONE;
            dst_bt_q   <= PIECE_NONE;
            dst_at_q   <= PIECE_NONE;
            row_q      <= '0;
            ready_q    <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          src_cnt_q  <= src_cnt_d;
          dst_cnt_q  <= dst_cnt_d;
          src_q      <= src_d;
          dst_q      <= dst_d;
          src_type_q <= src_type_d;
          dst_bt_q   <= dst_bt_d;
          dst_at_q   <= dst_at_d;
          row_q      <= row_q + 3'd1;
          if (row_q == 3'd7) state_q <= RESOLVE;
        end
        RESOLVE: begin
          move_q  <= move_d;
          error_q <= error_d;
          valid_q <= 1'b1;
          ready_q <= 1'b1;
          row_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_out = ready_q;
  assign move_out  = move_q;
  assign error_out = error_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_move_extractor.sv
// Scoreboard bench for move_extractor: directed board pairs with hand-derived moves,
// latency, back-to-back acceptance, ignored mid-scan requests and mid-scan reset.
module tb_move_extractor;
  import move_extractor_pkg::*;

  typedef struct packed {
    move_t m;
    logic  err;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  board_t before_in, after_in;
  logic   valid_in;
  logic   ready_out, error_out, valid_out;
  move_t  move_out;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   results_seen = 0;

  move_extractor #(.NB_PIECES(5)) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .before_in (before_in),
    .after_in  (after_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .move_out  (move_out),
    .error_out (error_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic move_t mk(input int s, input int d, input special_t sp);
    move_t m;
    m.src = 6'(s);
    m.dst = 6'(d);
    m.special = sp;
    return m;
  endfunction

  function automatic board_t put(input board_t b, input ptype_t p, input int sq, input bit white);
    board_t r = b;
    r.pos.pieces[p][sq] = 1'b1;
    r.pos.pieces_w[sq]  = white;
    return r;
  endfunction

  function automatic board_t clr(input board_t b, input ptype_t p, input int sq);
    board_t r = b;
    r.pos.pieces[p][sq] = 1'b0;
    return r;
  endfunction

  function automatic board_t start_board();
    board_t b = '0;
    b = put(b, PIECE_ROOK, 0, 1);   b = put(b, PIECE_ROOK, 7, 1);
    b = put(b, PIECE_KNIGHT, 1, 1); b = put(b, PIECE_KNIGHT, 6, 1);
    b = put(b, PIECE_BISHOP, 2, 1); b = put(b, PIECE_BISHOP, 5, 1);
    b = put(b, PIECE_QUEEN, 3, 1);
    b = put(b, PIECE_ROOK, 56, 0);   b = put(b, PIECE_ROOK, 63, 0);
    b = put(b, PIECE_KNIGHT, 57, 0); b = put(b, PIECE_KNIGHT, 62, 0);
    b = put(b, PIECE_BISHOP, 58, 0); b = put(b, PIECE_BISHOP, 61, 0);
    b = put(b, PIECE_QUEEN, 59, 0);
    for (int i = 0; i < 8; i++) begin
      b = put(b, PIECE_PAWN, 8 + i, 1);
      b = put(b, PIECE_PAWN, 48 + i, 0);
    end
    b.pos.king_w = 6'd4;
    b.pos.king_b = 6'd60;
    b.ply = 8'd0;
    return b;
  endfunction

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        results_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(valid_out), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("move_out", 32'(move_out), 32'(e.m));
          check("error_out", 32'(error_out), 32'(e.err));
        end
      end
    end
  end

  // Drives one request and returns at the falling edge after the accepting edge.
  task automatic issue(input board_t b, input board_t a);
    int n = 0;
    @(negedge clk);
    while (!ready_out && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", 32'(ready_out), 32'd1);
    before_in = b;
    after_in  = a;
    valid_in  = 1'b1;
    @(negedge clk);
    valid_in  = 1'b0;
  endtask

  // Accepting edge counts as 1; the result must appear after edge 10.
  task automatic wait_result();
    int lat = 1;
    while (lat < 21) begin
      @(posedge clk);
      lat++;
      #1;
      if (valid_out) break;
    end
    check("latency", 32'(lat), 32'd10);
  endtask

  task automatic run(input board_t b, input board_t a, input move_t m, input logic err);
    exp_q.push_back('{m: m, err: err});
    issue(b, a);
    wait_result();
  endtask

  initial begin
    board_t s, e4, two, cb, ca, eb, ea, pb, pq, pn, nb, na;
    int seen0, n;

    s   = start_board();
    e4  = put(clr(s, PIECE_PAWN, 12), PIECE_PAWN, 28, 1);
    two = put(clr(e4, PIECE_PAWN, 11), PIECE_PAWN, 27, 1);
    cb  = clr(clr(s, PIECE_BISHOP, 5), PIECE_KNIGHT, 6);
    ca  = put(clr(cb, PIECE_ROOK, 7), PIECE_ROOK, 5, 1);
    ca.pos.king_w = 6'd6;
    eb  = put(clr(e4, PIECE_PAWN, 51), PIECE_PAWN, 27, 0);
    eb.ply = 8'd1;
    ea  = clr(put(clr(eb, PIECE_PAWN, 27), PIECE_PAWN, 20, 0), PIECE_PAWN, 28);
    pb  = '0;
    pb.pos.king_w = 6'd0;
    pb.pos.king_b = 6'd63;
    pb  = put(pb, PIECE_PAWN, 52, 1);
    pq  = put(clr(pb, PIECE_PAWN, 52), PIECE_QUEEN, 60, 1);
    pn  = put(clr(pb, PIECE_PAWN, 52), PIECE_KNIGHT, 60, 1);
    nb  = s;
    nb.ply = 8'd1;
    na  = put(clr(nb, PIECE_KNIGHT, 62), PIECE_KNIGHT, 45, 0);

    rst_n = 1'b0;
    valid_in = 1'b0;
    before_in = '0;
    after_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready_out), 32'd1);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_move", 32'(move_out), 32'd0);
    check("reset_error", 32'(error_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(s, e4, mk(12, 28, SPECIAL_UNKNOWN), 1'b0);
    run(cb, ca, mk(4, 6, SPECIAL_CASTLE), 1'b0);
    run(eb, ea, mk(27, 20, SPECIAL_EN_PASSANT), 1'b0);
    run(pb, pq, mk(52, 60, SPECIAL_PROMOTE_QUEEN), 1'b0);
    run(pb, pn, mk(52, 60, SPECIAL_PROMOTE_KNIGHT), 1'b0);
    repeat (4) @(negedge clk);
    check("hold_move", 32'(move_out), 32'(mk(52, 60, SPECIAL_PROMOTE_KNIGHT)));
    check("hold_valid", 32'(valid_out), 32'd0);
    run(nb, na, mk(62, 45, SPECIAL_UNKNOWN), 1'b0);
    run(s, s, '0, 1'b1);
    run(s, two, '0, 1'b1);

    // A request pulsed mid-scan must be dropped.
    seen0 = results_seen;
    exp_q.push_back('{m: mk(12, 28, SPECIAL_UNKNOWN), err: 1'b0});
    issue(s, e4);
    repeat (3) @(negedge clk);
    before_in = s;
    after_in  = s;
    valid_in  = 1'b1;
    @(negedge clk);
    valid_in  = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("pulse_result_count", 32'(results_seen - seen0), 32'd1);

    // Reset during row 4 of the scan aborts the request silently.
    seen0 = results_seen;
    issue(s, e4);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready_out), 32'd1);
    check("abort_valid", 32'(valid_out), 32'd0);
    check("abort_move", 32'(move_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_result_count", 32'(results_seen - seen0), 32'd0);

    // A request held high is taken in the very cycle the previous result appears.
    seen0 = results_seen;
    exp_q.push_back('{m: mk(4, 6, SPECIAL_CASTLE), err: 1'b0});
    issue(cb, ca);
    before_in = nb;
    after_in  = na;
    valid_in  = 1'b1;
    exp_q.push_back('{m: mk(62, 45, SPECIAL_UNKNOWN), err: 1'b0});
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      if (ready_out) break;
      n++;
    end
    check("b2b_valid_with_ready", 32'(valid_out), 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("b2b_result_count", 32'(results_seen - seen0), 32'd2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
